// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, ALU ops,
// writeback select encodings and the FSM/type-class enums.
package multi_cycle_control_unit_pkg;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam logic [2:0] RFWD_ALU   = 3'd0;
  localparam logic [2:0] RFWD_LOAD  = 3'd1;
  localparam logic [2:0] RFWD_LUI   = 3'd2;
  localparam logic [2:0] RFWD_AUIPC = 3'd3;
  localparam logic [2:0] RFWD_PC4   = 3'd4;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExe,
    StMem,
    StWb,
    StTrap
  } mc_state_t;

  typedef enum logic [3:0] {
    TyR,
    TyI,
    TyS,
    TyL,
    TyB,
    TyLu,
    TyAu,
    TyJ,
    TyJl
  } mc_type_t;

endpackage

// File: rtl/multi_cycle_control_unit_decode.sv
// Combinational instruction decode: opcode/funct fields to type class and the
// state-independent datapath selects. The FSM decides when these are driven.
module mc_decode
  import multi_cycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic       valid_o,
  output mc_type_t   type_o,
  output logic       alu_src_o,
  output logic [2:0] rfwd_sel_o,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    valid_o    = 1'b1;
    type_o     = TyR;
    alu_src_o  = 1'b0;
    rfwd_sel_o = RFWD_ALU;
    alu_ctrl_o = ALU_ADD;
    case (opcode_i)
      OP_TYPE_R: begin
        type_o     = TyR;
        alu_ctrl_o = {funct7b5_i, funct3_i};
      end
      OP_TYPE_I: begin
        type_o     = TyI;
        alu_src_o  = 1'b1;
        // Only SRAI carries a meaningful bit 30; elsewhere it is immediate data.
        alu_ctrl_o = (funct3_i == 3'b101 && funct7b5_i) ? ALU_SRA : {1'b0, funct3_i};
      end
      OP_TYPE_S: begin
        type_o    = TyS;
        alu_src_o = 1'b1;
      end
      OP_TYPE_L: begin
        type_o    = TyL;
        alu_src_o = 1'b1;
      end
      OP_TYPE_B: begin
        type_o     = TyB;
        alu_ctrl_o = {funct7b5_i, funct3_i};
      end
      OP_TYPE_LU: begin
        type_o     = TyLu;
        rfwd_sel_o = RFWD_LUI;
      end
      OP_TYPE_AU: begin
        type_o     = TyAu;
        rfwd_sel_o = RFWD_AUIPC;
      end
      OP_TYPE_J: begin
        type_o     = TyJ;
        rfwd_sel_o = RFWD_PC4;
      end
      OP_TYPE_JL: begin
        type_o     = TyJl;
        rfwd_sel_o = RFWD_PC4;
      end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXE/MEM/WB with a bounded bus wait
// and a sticky TRAP state for illegal opcodes and bus timeouts.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter int unsigned RFWD_SEL_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           instrCode,
  input  logic                  instrValid,
  input  logic                  busReady,
  output logic                  pcEn,
  output logic                  irEn,
  output logic                  regFileWe,
  output logic                  aluSrcMuxSel,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  busWe,
  output logic                  busRe,
  output logic [RFWD_SEL_W-1:0] RFWDSrcMuxSel,
  output logic                  branch,
  output logic                  jal,
  output logic                  jalr,
  output logic                  illegal,
  output logic                  busErr
);

  localparam int unsigned CntW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(BUS_TIMEOUT);

  mc_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  logic            dec_valid;
  mc_type_t        dec_type;
  logic            dec_alu_src;
  logic [2:0]      dec_rfwd;
  logic [3:0]      dec_alu_ctrl;
  logic [3:0]      alu_ctrl;
  logic [2:0]      rfwd_sel;

  logic unused_instr;
  assign unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  mc_decode u_decode (
    .opcode_i  (instrCode[6:0]),
    .funct3_i  (instrCode[14:12]),
    .funct7b5_i(instrCode[30]),
    .valid_o   (dec_valid),
    .type_o    (dec_type),
    .alu_src_o (dec_alu_src),
    .rfwd_sel_o(dec_rfwd),
    .alu_ctrl_o(dec_alu_ctrl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      StFetch: begin
        if (instrValid) state_d = StDecode;
      end
      StDecode: begin
        if (dec_valid) begin
          state_d = StExe;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end
      StExe: begin
        state_d = (dec_type inside {TyS, TyL}) ? StMem : StFetch;
      end
      StMem: begin
        // Ready wins even in the cycle the wait count would expire.
        if (busReady) begin
          state_d = (dec_type == TyS) ? StFetch : StWb;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TimeoutCnt) begin
            state_d   = StTrap;
            bus_err_d = 1'b1;
          end
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    pcEn         = 1'b0;
    irEn         = 1'b0;
    regFileWe    = 1'b0;
    aluSrcMuxSel = 1'b0;
    alu_ctrl     = ALU_ADD;
    busWe        = 1'b0;
    busRe        = 1'b0;
    rfwd_sel     = RFWD_ALU;
    branch       = 1'b0;
    jal          = 1'b0;
    jalr         = 1'b0;
    case (state_q)
      StFetch: irEn = instrValid;
      StExe: begin
        aluSrcMuxSel = dec_alu_src;
        alu_ctrl     = dec_alu_ctrl;
        rfwd_sel     = dec_rfwd;
        regFileWe    = dec_type inside {TyR, TyI, TyLu, TyAu, TyJ, TyJl};
        pcEn         = !(dec_type inside {TyS, TyL});
        branch       = (dec_type == TyB);
        jal          = dec_type inside {TyJ, TyJl};
        jalr         = (dec_type == TyJl);
      end
      StMem: begin
        aluSrcMuxSel = 1'b1;
        if (dec_type == TyS) begin
          busWe = 1'b1;
          pcEn  = busReady;
        end else begin
          busRe = 1'b1;
        end
      end
      StWb: begin
        rfwd_sel  = RFWD_LOAD;
        regFileWe = 1'b1;
        pcEn      = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluControl    = ALU_CTRL_W'(alu_ctrl);
  assign RFWDSrcMuxSel = RFWD_SEL_W'(rfwd_sel);
  assign illegal       = illegal_q;
  assign busErr        = bus_err_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction cycle traces built from the
// instruction-level rules, a table of decode vectors, corner sequences and random runs.
module tb_multi_cycle_control_unit;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] instrCode = '0;
  logic        instrValid = 1'b0;
  logic        busReady = 1'b0;
  logic        pcEn, irEn, regFileWe, aluSrcMuxSel, busWe, busRe;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch, jal, jalr, illegal, busErr;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(
    .BUS_TIMEOUT(TMO),
    .ALU_CTRL_W (4),
    .RFWD_SEL_W (3)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instrCode    (instrCode),
    .instrValid   (instrValid),
    .busReady     (busReady),
    .pcEn         (pcEn),
    .irEn         (irEn),
    .regFileWe    (regFileWe),
    .aluSrcMuxSel (aluSrcMuxSel),
    .aluControl   (aluControl),
    .busWe        (busWe),
    .busRe        (busRe),
    .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .illegal      (illegal),
    .busErr       (busErr)
  );

  typedef struct packed {
    logic       pc;
    logic       ir;
    logic       we;
    logic       src;
    logic [3:0] alu;
    logic       bwe;
    logic       bre;
    logic [2:0] rfwd;
    logic       br;
    logic       jal;
    logic       jalr;
    logic       ill;
    logic       berr;
  } outs_t;

  typedef struct {
    logic  iv;
    logic  br;
    outs_t exp;
  } step_t;

  typedef struct {
    logic [31:0] ins;
    outs_t       exe;
  } vec_t;

  localparam outs_t ZERO = '0;

  step_t       trace[$];
  outs_t       got_q[$];
  logic [31:0] cur_ins;
  string       tag;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        tbl[14];

  function automatic outs_t sample();
    outs_t o;
    o.pc = pcEn; o.ir = irEn; o.we = regFileWe; o.src = aluSrcMuxSel;
    o.alu = aluControl; o.bwe = busWe; o.bre = busRe; o.rfwd = RFWDSrcMuxSel;
    o.br = branch; o.jal = jal; o.jalr = jalr; o.ill = illegal; o.berr = busErr;
    return o;
  endfunction

  function automatic void check(string nm, int idx, outs_t got, outs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h required %h", nm, idx, got, exp);
    end
  endfunction

  function automatic void check_int(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endfunction

  function automatic outs_t mk(logic pc, logic we, logic src, logic [3:0] alu,
                               logic [2:0] rfwd, logic br, logic j, logic jr);
    outs_t o = ZERO;
    o.pc = pc; o.we = we; o.src = src; o.alu = alu; o.rfwd = rfwd;
    o.br = br; o.jal = j; o.jalr = jr;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic known(logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
  endfunction

  // Expected outputs during the execute cycle, straight from the per-type rules.
  function automatic outs_t exe_outs(logic [31:0] ins);
    logic [6:0] op  = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic       b30 = ins[30];
    case (op)
      7'h33: return mk(1'b1, 1'b1, 1'b0, {b30, f3}, 3'd0, 1'b0, 1'b0, 1'b0);
      7'h13: return mk(1'b1, 1'b1, 1'b1, (f3 == 3'd5 && b30) ? 4'hd : {1'b0, f3},
                       3'd0, 1'b0, 1'b0, 1'b0);
      7'h37: return mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd2, 1'b0, 1'b0, 1'b0);
      7'h17: return mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b0);
      7'h63: return mk(1'b1, 1'b0, 1'b0, {b30, f3}, 3'd0, 1'b1, 1'b0, 1'b0);
      7'h6f: return mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0, 1'b1, 1'b0);
      7'h67: return mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0, 1'b1, 1'b1);
      7'h23, 7'h03: return mk(1'b0, 1'b0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      default: return ZERO;
    endcase
  endfunction

  function automatic void push(logic iv, logic br, outs_t e);
    step_t s;
    s.iv = iv; s.br = br; s.exp = e;
    trace.push_back(s);
  endfunction

  // Whole-instruction cycle trace: fw idle fetch cycles, then bus ready after bw waits.
  function automatic void build(logic [31:0] ins, int fw, int bw);
    outs_t e;
    logic  store, done;
    trace.delete();
    cur_ins = ins;
    for (int i = 0; i < fw; i++) push(1'b0, rb(), ZERO);
    e = ZERO; e.ir = 1'b1;
    push(1'b1, rb(), e);
    push(rb(), rb(), ZERO);
    if (!known(ins[6:0])) begin
      e = ZERO; e.ill = 1'b1;
      repeat (3) push(rb(), rb(), e);
      return;
    end
    push(rb(), rb(), exe_outs(ins));
    if (ins[6:0] == 7'h23 || ins[6:0] == 7'h03) begin
      store = (ins[6:0] == 7'h23);
      done  = 1'b0;
      for (int k = 0; k < int'(TMO); k++) begin
        e = ZERO; e.src = 1'b1; e.bwe = store; e.bre = !store;
        if (k == bw) begin
          e.pc = store;
          push(rb(), 1'b1, e);
          done = 1'b1;
          break;
        end
        push(rb(), 1'b0, e);
      end
      if (!done) begin
        e = ZERO; e.berr = 1'b1;
        repeat (3) push(rb(), rb(), e);
      end else if (!store) begin
        push(rb(), rb(), mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0));
      end
    end
  endfunction

  task automatic apply(input int lim);
    outs_t got;
    for (int i = 0; i < trace.size() && i < lim; i++) begin
      instrCode  = cur_ins;
      instrValid = trace[i].iv;
      busReady   = trace[i].br;
      @(negedge clk);
      got = sample();
      check(tag, i, got, trace[i].exp);
      got_q.push_back(got);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    instrValid = 1'b0;
    busReady   = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("reset_values", 0, sample(), ZERO);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input int fw, input int bw);
    tag = nm;
    build(ins, fw, bw);
    got_q.delete();
    apply(1000);
  endtask

  function automatic int pc_pulses();
    int n = 0;
    foreach (got_q[i]) n += int'(got_q[i].pc);
    return n;
  endfunction

  initial begin
    logic [31:0] ins;
    logic [6:0]  bad_ops[5];
    outs_t       e;

    tbl[0]  = '{32'h002081B3, mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{32'h402081B3, mk(1'b1, 1'b1, 1'b0, 4'h8, 3'd0, 1'b0, 1'b0, 1'b0)};
    tbl[2]  = '{32'h4010D093, mk(1'b1, 1'b1, 1'b1, 4'hd, 3'd0, 1'b0, 1'b0, 1'b0)};
    tbl[3]  = '{32'h00109093, mk(1'b1, 1'b1, 1'b1, 4'h1, 3'd0, 1'b0, 1'b0, 1'b0)};
    tbl[4]  = '{32'h0010D093, mk(1'b1, 1'b1, 1'b1, 4'h5, 3'd0, 1'b0, 1'b0, 1'b0)};
    tbl[5]  = '{32'hFFF0C093, mk(1'b1, 1'b1, 1'b1, 4'h4, 3'd0, 1'b0, 1'b0, 1'b0)};
    tbl[6]  = '{32'h123452B7, mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd2, 1'b0, 1'b0, 1'b0)};
    tbl[7]  = '{32'h12345297, mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b0)};
    tbl[8]  = '{32'h00208063, mk(1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0)};
    tbl[9]  = '{32'h0020C063, mk(1'b1, 1'b0, 1'b0, 4'h4, 3'd0, 1'b1, 1'b0, 1'b0)};
    tbl[10] = '{32'h000000EF, mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0, 1'b1, 1'b0)};
    tbl[11] = '{32'h000100E7, mk(1'b1, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0, 1'b1, 1'b1)};
    tbl[12] = '{32'h0020A023, mk(1'b0, 1'b0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0)};
    tbl[13] = '{32'h0000A283, mk(1'b0, 1'b0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0)};
    bad_ops = '{7'h7f, 7'h00, 7'h0b, 7'h73, 7'h0f};

    #2;
    do_reset();

    // Decode table, each instruction issued back to back with no waits.
    foreach (tbl[i]) begin
      run("table_trace", tbl[i].ins, 0, 0);
      check("table_exe", i, got_q[2], tbl[i].exe);
      check_int("table_pc_pulses", pc_pulses(), 1);
    end

    run("lw_wait3", 32'h0000A283, 0, 3);
    check_int("lw_wait3_pc_pulses", pc_pulses(), 1);
    run("lw_wait15_edge", 32'h0000A283, 2, int'(TMO) - 1);
    run("sw_wait15_edge", 32'h0020A023, 1, int'(TMO) - 1);

    run("sw_timeout", 32'h0020A023, 0, 100);
    check_int("sw_timeout_pc_pulses", pc_pulses(), 0);
    do_reset();
    run("lw_timeout_edge", 32'h0000A283, 0, int'(TMO));
    do_reset();

    run("illegal_7f", 32'h0000007F, 1, 0);
    check_int("illegal_pc_pulses", pc_pulses(), 0);
    do_reset();
    run("after_illegal", 32'h002081B3, 0, 0);

    // Reset pulsed while a load is waiting in MEM.
    tag = "rst_mid_load";
    build(32'h0000A283, 0, 10);
    got_q.delete();
    apply(5);
    e = ZERO; e.src = 1'b1; e.bre = 1'b1;
    check("rst_mid_busy", 0, sample(), e);
    instrValid = 1'b0;
    busReady   = 1'b1;
    reset_n    = 1'b0;
    #1;
    check("rst_mid_drop", 0, sample(), ZERO);
    @(posedge clk);
    #1;
    check("rst_mid_hold", 0, sample(), ZERO);
    reset_n = 1'b1;
    run("post_reset_fetch", 32'h0000A283, 0, 0);

    for (int n = 0; n < 150; n++) begin
      ins = $urandom();
      if ($urandom_range(0, 19) == 0) ins[6:0] = bad_ops[$urandom_range(0, 4)];
      else ins[6:0] = exe_outs_op($urandom_range(0, 8));
      run("random", ins, $urandom_range(0, 3), $urandom_range(0, 5));
      if (!known(ins[6:0])) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic [6:0] exe_outs_op(int unsigned k);
    case (k)
      0: return 7'h33;
      1: return 7'h13;
      2: return 7'h23;
      3: return 7'h03;
      4: return 7'h63;
      5: return 7'h37;
      6: return 7'h17;
      7: return 7'h6f;
      default: return 7'h67;
    endcase
  endfunction

endmodule
